// File: rtl/xnor_match_tracker.sv
// Scores each valid XNOR agreement vector, classifies it as full/near/miss and
// tracks operand alignment with a SEARCH/LOCKED FSM. Two registered stages.
module xnor_match_tracker #(
    parameter int WIDTH         = 6,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_MISSES = 2,
    parameter int MIN_BITS      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] xn,
    input  logic             clear,
    output logic             out_valid,
    output logic [2:0]       ones_count,
    output logic             full_match,
    output logic             near_match,
    output logic             locked,
    output logic [3:0]       match_run,
    output logic [7:0]       miss_total
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Valid/ready: there is no backpressure; a sample is accepted on every
    // edge where in_valid=1 and clear=0, and each accepted sample yields
    // exactly one out_valid pulse two edges later unless clear/reset intervene.

    state_t           state_q, state_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       ones_q, ones_d;
    logic             full_q, full_d;
    logic             near_q, near_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [7:0]       miss_total_q, miss_total_d;
    logic [3:0]       miss_ctr_q, miss_ctr_d;

    logic [2:0]       pop;
    logic             is_full;
    logic             is_near;
    logic             is_miss;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {2'b00, x1_q[i]};
        end
    end

    assign is_full = (x1_q == {WIDTH{1'b1}});
    assign is_near = !is_full && (pop >= 3'(MIN_BITS));
    assign is_miss = !is_full && !is_near;

    always_comb begin
        state_d      = state_q;
        v1_d         = in_valid;
        x1_d         = in_valid ? xn : x1_q;
        out_valid_d  = v1_q;
        ones_d       = ones_q;
        full_d       = full_q;
        near_d       = near_q;
        match_run_d  = match_run_q;
        miss_total_d = miss_total_q;
        miss_ctr_d   = miss_ctr_q;

        if (v1_q) begin
            ones_d = pop;
            full_d = is_full;
            near_d = is_near;

            if (is_full) begin
                match_run_d = (match_run_q == 4'hF) ? 4'hF : match_run_q + 4'd1;
            end else begin
                match_run_d = 4'd0;
            end

            if (is_miss && (miss_total_q != 8'hFF)) begin
                miss_total_d = miss_total_q + 8'd1;
            end

            // The lock test uses the unsaturated run so a 15-long run still counts.
            case (state_q)
                SEARCH: begin
                    if (is_full && (({1'b0, match_run_q} + 5'd1) >= 5'(LOCK_COUNT))) begin
                        state_d    = LOCKED;
                        miss_ctr_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_full) begin
                        miss_ctr_d = 4'd0;
                    end else if (is_miss) begin
                        if ((miss_ctr_q + 4'd1) == 4'(UNLOCK_MISSES)) begin
                            state_d     = SEARCH;
                            match_run_d = 4'd0;
                            miss_ctr_d  = 4'd0;
                        end else begin
                            miss_ctr_d = miss_ctr_q + 4'd1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Flush drops both the sample in stage 1 and the one arriving now.
        if (clear) begin
            state_d      = SEARCH;
            v1_d         = 1'b0;
            x1_d         = '0;
            out_valid_d  = 1'b0;
            ones_d       = '0;
            full_d       = 1'b0;
            near_d       = 1'b0;
            match_run_d  = '0;
            miss_total_d = '0;
            miss_ctr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            v1_q         <= 1'b0;
            x1_q         <= '0;
            out_valid_q  <= 1'b0;
            ones_q       <= '0;
            full_q       <= 1'b0;
            near_q       <= 1'b0;
            match_run_q  <= '0;
            miss_total_q <= '0;
            miss_ctr_q   <= '0;
        end else begin
            state_q      <= state_d;
            v1_q         <= v1_d;
            x1_q         <= x1_d;
            out_valid_q  <= out_valid_d;
            ones_q       <= ones_d;
            full_q       <= full_d;
            near_q       <= near_d;
            match_run_q  <= match_run_d;
            miss_total_q <= miss_total_d;
            miss_ctr_q   <= miss_ctr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ones_count = ones_q;
    assign full_match = full_q;
    assign near_match = near_q;
    assign locked     = (state_q == LOCKED);
    assign match_run  = match_run_q;
    assign miss_total = miss_total_q;

endmodule

// File: tb/tb_xnor_match_tracker.sv
// Directed bench for xnor_match_tracker: a vector table for the main flow plus
// hand-written sequences for saturation, clear and mid-stream reset.
module tb_xnor_match_tracker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] xn;
    logic       clear;
    logic       out_valid;
    logic [2:0] ones_count;
    logic       full_match;
    logic       near_match;
    logic       locked;
    logic [3:0] match_run;
    logic [7:0] miss_total;

    int errors = 0;
    int checks = 0;

    xnor_match_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .xn         (xn),
        .clear      (clear),
        .out_valid  (out_valid),
        .ones_count (ones_count),
        .full_match (full_match),
        .near_match (near_match),
        .locked     (locked),
        .match_run  (match_run),
        .miss_total (miss_total)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, summary forced");
        errors = errors + 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // Each row: inputs driven for one edge, and the outputs expected right
    // after that edge (which reflect the sample of the previous row).
    typedef struct {
        logic       iv;
        logic [5:0] xn;
        logic       ov;
        logic [2:0] oc;
        logic       fm;
        logic       nm;
        logic       lk;
        logic [3:0] mr;
        logic [7:0] mt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic iv, logic [5:0] x, logic ov, logic [2:0] oc,
                                logic fm, logic nm, logic lk, logic [3:0] mr,
                                logic [7:0] mt);
        vec_t v;
        v.iv = iv; v.xn = x; v.ov = ov; v.oc = oc; v.fm = fm;
        v.nm = nm; v.lk = lk; v.mr = mr; v.mt = mt;
        return v;
    endfunction

    // scoreboard
    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic ov, input logic [2:0] oc,
                           input logic fm, input logic nm, input logic lk,
                           input logic [3:0] mr, input logic [7:0] mt);
        chk("out_valid",  idx, {7'd0, out_valid},  {7'd0, ov});
        chk("ones_count", idx, {5'd0, ones_count}, {5'd0, oc});
        chk("full_match", idx, {7'd0, full_match}, {7'd0, fm});
        chk("near_match", idx, {7'd0, near_match}, {7'd0, nm});
        chk("locked",     idx, {7'd0, locked},     {7'd0, lk});
        chk("match_run",  idx, {4'd0, match_run},  {4'd0, mr});
        chk("miss_total", idx, miss_total,         mt);
    endtask

    // driver
    task automatic step(input logic iv, input logic [5:0] x, input logic clr);
        in_valid = iv;
        xn       = x;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        xn       = '0;
        clear    = 1'b0;

        // main-flow table: lock, near tolerance, unlock, search runs, bubbles
        tbl[0]  = mk(1, 6'h3F, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 6'h3F, 1, 6, 1, 0, 0, 1, 0);
        tbl[2]  = mk(1, 6'h3F, 1, 6, 1, 0, 0, 2, 0);
        tbl[3]  = mk(1, 6'h3F, 1, 6, 1, 0, 0, 3, 0);
        tbl[4]  = mk(1, 6'h3E, 1, 6, 1, 0, 1, 4, 0);
        tbl[5]  = mk(1, 6'h3E, 1, 5, 0, 1, 1, 0, 0);
        tbl[6]  = mk(1, 6'h3E, 1, 5, 0, 1, 1, 0, 0);
        tbl[7]  = mk(1, 6'h00, 1, 5, 0, 1, 1, 0, 0);
        tbl[8]  = mk(1, 6'h07, 1, 0, 0, 0, 1, 0, 1);
        tbl[9]  = mk(0, 6'h00, 1, 3, 0, 0, 0, 0, 2);
        tbl[10] = mk(1, 6'h3F, 0, 3, 0, 0, 0, 0, 2);
        tbl[11] = mk(1, 6'h3F, 1, 6, 1, 0, 0, 1, 2);
        tbl[12] = mk(1, 6'h3F, 1, 6, 1, 0, 0, 2, 2);
        tbl[13] = mk(1, 6'h00, 1, 6, 1, 0, 0, 3, 2);
        tbl[14] = mk(1, 6'h3F, 1, 0, 0, 0, 0, 0, 3);
        tbl[15] = mk(1, 6'h3F, 1, 6, 1, 0, 0, 1, 3);
        tbl[16] = mk(0, 6'h3F, 1, 6, 1, 0, 0, 2, 3);
        tbl[17] = mk(1, 6'h3F, 0, 6, 1, 0, 0, 2, 3);
        tbl[18] = mk(0, 6'h00, 1, 6, 1, 0, 0, 3, 3);
        tbl[19] = mk(1, 6'h3F, 0, 6, 1, 0, 0, 3, 3);
        tbl[20] = mk(1, 6'h1F, 1, 6, 1, 0, 1, 4, 3);
        tbl[21] = mk(1, 6'h0F, 1, 5, 0, 1, 1, 0, 3);
        tbl[22] = mk(1, 6'h3F, 1, 4, 0, 0, 1, 0, 4);
        tbl[23] = mk(1, 6'h0F, 1, 6, 1, 0, 1, 1, 4);
        tbl[24] = mk(1, 6'h3E, 1, 4, 0, 0, 1, 0, 5);
        tbl[25] = mk(1, 6'h01, 1, 5, 0, 1, 1, 0, 5);
        tbl[26] = mk(0, 6'h00, 1, 1, 0, 0, 0, 0, 6);
        tbl[27] = mk(0, 6'h00, 0, 1, 0, 0, 0, 0, 6);

        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].iv, tbl[i].xn, 1'b0);
            chk_all(i, tbl[i].ov, tbl[i].oc, tbl[i].fm, tbl[i].nm,
                    tbl[i].lk, tbl[i].mr, tbl[i].mt);
        end

        // match_run saturates at 15 across a long full run; lock after the 4th
        for (int k = 0; k <= 17; k++) begin
            step((k < 17), 6'h3F, 1'b0);
            if (k >= 1) begin
                chk("sat_out_valid", k, {7'd0, out_valid}, 8'd1);
                chk("sat_match_run", k, {4'd0, match_run}, (k > 15) ? 8'd15 : 8'(k));
                chk("sat_locked",    k, {7'd0, locked},    (k >= 4) ? 8'd1 : 8'd0);
            end
        end

        // clear with one sample in stage 1 and one presented alongside clear
        step(1'b1, 6'h00, 1'b0);
        step(1'b1, 6'h3F, 1'b1);
        chk_all(100, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 6'h00, 1'b0);
        chk_all(101, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 6'h00, 1'b0);
        chk("clr_out_valid", 102, {7'd0, out_valid}, 8'd0);

        // miss_total saturates at 255
        for (int k = 0; k <= 257; k++) begin
            step((k < 257), 6'h00, 1'b0);
            if (k >= 1) begin
                chk("msat_out_valid",  k, {7'd0, out_valid}, 8'd1);
                chk("msat_miss_total", k, miss_total, (k > 255) ? 8'd255 : 8'(k));
            end
        end
        chk("msat_locked", 300, {7'd0, locked}, 8'd0);

        // asynchronous reset with samples in flight
        step(1'b1, 6'h3F, 1'b0);
        step(1'b1, 6'h3F, 1'b0);
        chk("pre_rst_out_valid", 200, {7'd0, out_valid}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk_all(201, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step(1'b0, 6'h00, 1'b0);
        chk_all(202, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 6'h3F, 1'b0);
        step(1'b0, 6'h00, 1'b0);
        chk_all(203, 1, 6, 1, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
